// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bundle: branch resolution inputs, instruction-memory request and
// response channels, and the instruction stream toward decode.
interface pc_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            ResolveValid;
    logic [XLEN-1:0] ResolvePC;
    logic            PCAsrc;
    logic            PCBsrc;
    logic [XLEN-1:0] Imm;
    logic [XLEN-1:0] Rs1;
    logic            ImemReqValid;
    logic            ImemReqReady;
    logic [XLEN-1:0] ImemReqAddr;
    logic            ImemRespValid;
    logic [31:0]     ImemRespData;
    logic            InstValid;
    logic            InstReady;
    logic [31:0]     InstData;
    logic [XLEN-1:0] InstPC;
    logic            MisalignFault;

    // Fetch unit side
    modport master (
        input  ResolveValid, ResolvePC, PCAsrc, PCBsrc, Imm, Rs1,
        input  ImemReqReady, ImemRespValid, ImemRespData, InstReady,
        output ImemReqValid, ImemReqAddr, InstValid, InstData, InstPC, MisalignFault
    );

    // Environment side (branch unit, instruction memory, decode)
    modport slave (
        output ResolveValid, ResolvePC, PCAsrc, PCBsrc, Imm, Rs1,
        output ImemReqReady, ImemRespValid, ImemRespData, InstReady,
        input  ImemReqValid, ImemReqAddr, InstValid, InstData, InstPC, MisalignFault
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter owner and instruction fetcher. Issues one outstanding
// request at a time, buffers responses in a small FIFO toward decode and
// flushes on a redirect. Stale responses are filtered by an epoch bit that
// flips on every redirect.
module pc_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    pc_fetch_unit_if.master  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [CW:0]     DEPTH_L = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t          state_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] req_addr_r;
    logic            outstanding_r;
    logic            epoch_r;
    logic            req_epoch_r;
    logic            req_valid_r;
    logic            inst_valid_r;
    logic            fault_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [31:0]     fifo_data_r [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc_r   [FIFO_DEPTH];

    logic            redirect_s;
    logic            handshake_s;
    logic            resp_s;
    logic            push_s;
    logic            pop_s;
    logic            flush_s;
    logic [XLEN-1:0] base_s;
    logic [XLEN-1:0] sum_s;
    logic [XLEN-1:0] target_s;
    logic            aligned_s;
    state_t          state_nxt_s;
    logic [XLEN-1:0] pc_nxt_s;
    logic            out_nxt_s;
    logic            epoch_nxt_s;
    logic            fault_nxt_s;
    logic [CW-1:0]   count_nxt_s;
    logic [CW:0]     credit_sum_s;
    logic            req_valid_nxt_s;

    assign redirect_s  = bus.ResolveValid && !bus.PCAsrc && (state_r != HALT);
    assign handshake_s = req_valid_r && bus.ImemReqReady;
    assign resp_s      = outstanding_r && bus.ImemRespValid;
    assign push_s      = resp_s && (state_r == WAIT) && (req_epoch_r == epoch_r) && !redirect_s;
    assign pop_s       = inst_valid_r && bus.InstReady && !redirect_s;

    // Redirect target: PC- or rs1-relative, JALR clears bit 0 after the add
    always_comb begin
        if (bus.PCBsrc) begin
            base_s = bus.Rs1;
        end else begin
            base_s = bus.ResolvePC;
        end
        sum_s = base_s + bus.Imm;
        if (bus.PCBsrc) begin
            target_s = {sum_s[XLEN-1:1], 1'b0};
        end else begin
            target_s = sum_s;
        end
        aligned_s = (target_s[1:0] == 2'b00);
    end

    // Next-state, PC, outstanding and epoch; a redirect overrides normal flow
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        out_nxt_s   = outstanding_r;
        epoch_nxt_s = epoch_r;
        fault_nxt_s = 1'b0;
        flush_s     = 1'b0;
        case (state_r)
            FETCH: begin
                if (handshake_s) begin
                    out_nxt_s   = 1'b1;
                    pc_nxt_s    = pc_r + PC_STEP;
                    state_nxt_s = WAIT;
                end else begin
                    out_nxt_s   = outstanding_r;
                end
            end
            WAIT: begin
                if (resp_s) begin
                    out_nxt_s   = 1'b0;
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            HALT: begin
                if (resp_s) begin
                    out_nxt_s = 1'b0;
                end else begin
                    out_nxt_s = outstanding_r;
                end
            end
            default: begin
                state_nxt_s = FETCH;
                out_nxt_s   = 1'b0;
            end
        endcase
        if (redirect_s) begin
            epoch_nxt_s = ~epoch_r;
            flush_s     = 1'b1;
            if (aligned_s) begin
                pc_nxt_s = target_s;
                if (out_nxt_s) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = FETCH;
                end
            end else begin
                fault_nxt_s = 1'b1;
                state_nxt_s = HALT;
            end
        end else begin
            flush_s = 1'b0;
        end
    end

    // Occupancy and request credit: never ask for more than the FIFO can hold
    always_comb begin
        if (flush_s) begin
            count_nxt_s = {CW{1'b0}};
        end else begin
            count_nxt_s = count_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
        end
        credit_sum_s    = {1'b0, count_nxt_s} + {{CW{1'b0}}, out_nxt_s};
        req_valid_nxt_s = (state_nxt_s == FETCH) && (credit_sum_s < DEPTH_L);
    end

    // Control state, FIFO pointers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= FETCH;
            pc_r          <= RESET_PC;
            req_addr_r    <= RESET_PC;
            outstanding_r <= 1'b0;
            epoch_r       <= 1'b0;
            req_epoch_r   <= 1'b1;
            req_valid_r   <= 1'b0;
            inst_valid_r  <= 1'b0;
            fault_r       <= 1'b0;
            wr_ptr_r      <= {AW{1'b0}};
            rd_ptr_r      <= {AW{1'b0}};
            count_r       <= {CW{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            pc_r          <= pc_nxt_s;
            outstanding_r <= out_nxt_s;
            epoch_r       <= epoch_nxt_s;
            req_valid_r   <= req_valid_nxt_s;
            inst_valid_r  <= (count_nxt_s != {CW{1'b0}});
            fault_r       <= fault_nxt_s;
            count_r       <= count_nxt_s;
            if (handshake_s) begin
                req_epoch_r <= epoch_r;
                req_addr_r  <= pc_r;
            end
            if (flush_s) begin
                wr_ptr_r <= {AW{1'b0}};
                rd_ptr_r <= {AW{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1'b1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1'b1);
                end
            end
        end
    end

    // Instruction buffer storage, written at the tail on an accepted response
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_data_r[wr_ptr_r] <= bus.ImemRespData;
            fifo_pc_r[wr_ptr_r]   <= req_addr_r;
        end
    end

    assign bus.ImemReqValid  = req_valid_r;
    assign bus.ImemReqAddr   = pc_r;
    assign bus.InstValid     = inst_valid_r;
    assign bus.InstData      = fifo_data_r[rd_ptr_r];
    assign bus.InstPC        = fifo_pc_r[rd_ptr_r];
    assign bus.MisalignFault = fault_r;
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Owns the program counter and drives instruction fetch. It consumes the PC mux selects (PCAsrc, PCBsrc) from the branch condition unit and computes the next PC: sequential PC+4, PC+imm for branches/JAL, or rs1+imm for JALR. It issues single-outstanding requests to instruction memory, buffers returned instructions in a small FIFO toward decode, and flushes on redirect.

Parameters:
XLEN, 32, datapath and address width
RESET_PC, 32'h0000_0000, fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
ResolveValid  input  1  branch unit has evaluated a control-flow instruction this cycle
ResolvePC  input  XLEN  PC of the resolving instruction
PCAsrc  input  1  0 = take offset (redirect), 1 = sequential (no redirect)
PCBsrc  input  1  0 = base is ResolvePC, 1 = base is Rs1 (JALR)
Imm  input  XLEN  sign-extended offset
Rs1  input  XLEN  rs1 operand value
ImemReqValid  output  1  fetch request valid
ImemReqReady  input  1  memory accepts request
ImemReqAddr  output  XLEN  fetch address
ImemRespValid  input  1  response valid (one per accepted request, >=1 cycle later)
ImemRespData  input  32  fetched instruction word
InstValid  output  1  FIFO head valid toward decode
InstReady  input  1  decode accepts head
InstData  output  32  instruction at FIFO head
InstPC  output  XLEN  PC of instruction at FIFO head
MisalignFault  output  1  one-cycle pulse on misaligned redirect target

Behaviour:
- Reset (sync, active-high, when reset=1 at clk edge): fetch PC <= RESET_PC; FIFO empty; outstanding <= 0; epoch <= 0; state <= FETCH; ImemReqValid=0, InstValid=0, MisalignFault=0, ImemReqAddr=RESET_PC. Reset overrides all other inputs in the same cycle, including mid-request; any response arriving after reset for a pre-reset request is dropped (epoch toggled relative to the tagged request).
- States: FETCH, WAIT, HALT.
  - FETCH: ImemReqValid=1 when (FIFO occupancy + outstanding) < FIFO_DEPTH. On ImemReqValid&&ImemReqReady: latch req epoch, outstanding<=1, fetch PC <= fetch PC+4, -> WAIT.
  - WAIT: ImemReqValid=0. On ImemRespValid: if tag epoch == current epoch, push {ImemRespData, request address} into FIFO; else discard. outstanding<=0, -> FETCH. Response and new request never overlap in one cycle (single outstanding).
  - HALT: no requests; responses still consumed and discarded; FIFO still drains to decode; exit only by reset.
- Redirect: ResolveValid && !PCAsrc. Target = (PCBsrc ? Rs1 : ResolvePC) + Imm, mod 2^XLEN (wraps, no overflow flag); when PCBsrc=1, bit0 cleared afterward.
  - Target[1:0]==0: next cycle fetch PC=target; FIFO flushed (occupancy 0, InstValid=0); epoch toggles; state: if outstanding -> stays WAIT (response discarded), else FETCH. A request handshaking in the redirect cycle is treated as outstanding and discarded.
  - Target[1:0]!=0: MisalignFault=1 for exactly one cycle, FIFO flushed, -> HALT.
- ResolveValid && PCAsrc: no effect (PCBsrc ignored).
- Redirect same cycle as FIFO pop: pop ignored, flush wins. Same cycle as valid response: response discarded.
- FIFO: push and pop in same cycle allowed when nonempty; occupancy unchanged. Never overflows due to the credit rule. InstData/InstPC stable while InstValid&&!InstReady.
- Latency: reset deassert -> ImemReqValid=1 next cycle; response accepted -> InstValid=1 the following cycle; redirect -> request to target no earlier than 1 cycle after.

Test Plan:
- Reset, ImemReqReady=1, 1-cycle memory, InstReady=1 -> requests 0x0,0x4,0x8; InstPC sequence 0x0,0x4,0x8 with matching data.
- InstReady=0 from start -> exactly 2 instructions buffered (PC 0x0,0x4), ImemReqValid stays 0; raise InstReady -> fetch resumes at 0x8.
- Branch: ResolveValid=1, PCAsrc=0, PCBsrc=0, ResolvePC=0x10, Imm=0xFFFF_FFF8 while request outstanding -> FIFO flushed, in-flight response dropped, next ImemReqAddr=0x08.
- JALR: PCBsrc=1, Rs1=0x101, Imm=0x3 -> target 0x104; ImemReqAddr=0x104, no fault.
- Misaligned: PCBsrc=0, ResolvePC=0x20, Imm=0x2 -> MisalignFault high one cycle, ImemReqValid stays 0 until reset, then fetch at RESET_PC.
- Reset asserted while WAIT; response arrives the cycle after reset release -> response not enqueued, InstValid stays 0 until fresh fetch of 0x0 returns.
